serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Bit-serial N-bit adder controller. Sequences a single 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands.
- Holds the carry in a register between bit slices. Start/busy/done handshake.
- Sits between a requester and the 1-bit adder datapath. Trades latency for area where a parallel adder is not justified.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- op_a  input  WIDTH  operand A; sampled on the accepting edge.
- op_b  input  WIDTH  operand B; sampled on the accepting edge.
- cin  input  1  carry-in; sampled on the accepting edge.
- busy  output  1  high while bit slices are being processed.
- done  output  1  one-cycle pulse when result becomes valid.
- sum  output  WIDTH  result; held stable from done until next accepted start.
- cout  output  1  final carry-out; held with sum.

Behaviour:
- All outputs are registered. Reset values: busy=0, done=0, sum=0, cout=0. On reset, state=IDLE and the internal shift registers, carry and bit counter clear to 0.
- Reset has priority over every other event, including mid-RUN. An operation in progress is discarded with no done pulse.
- FSM states:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE, start=1: latch op_a/op_b into shift registers A/B, carry<=cin, cnt<=0, go to RUN.
  - IDLE, start=0: stay in IDLE.
  - RUN, each edge: process one bit slice.
    - s = A[0]^B[0]^carry.
    - carry <= majority(A[0],B[0],carry).
    - A,B shift right by 1.
    - Result shift register shifts right with s entering at the MSB.
    - cnt <= cnt+1.
  - RUN, edge where cnt==WIDTH-1: last slice. sum <= final result, cout <= final carry, go to DONE.
  - DONE, start=0: go to IDLE; done drops and sum/cout hold.
  - DONE, start=1: accept as in IDLE (back-to-back) and go to RUN; done drops the next cycle.
- start while in RUN is ignored; operands are not re-sampled.
- sum and cout do not change during RUN. They update only on the edge entering DONE.
- Latency: start accepted at edge E0. busy=1 after E0 through E(WIDTH); done=1 for exactly the one cycle after E(WIDTH). Sustained throughput: one addition per WIDTH+1 cycles.
- Arithmetic: {cout,sum} = op_a + op_b + cin, unsigned, modulo 2^(WIDTH+1). No truncation beyond that.
- Bit counter width: ceil(log2(WIDTH)), minimum 1.
- The design contains no combinational path from any input to any output.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - Carry into the MSB slice is captured during the last RUN cycle.
  - ovf = carry_into_msb ^ final carry (two's-complement signed overflow).
  - ovf updates with sum/cout on the edge entering DONE and holds with them.
- Undefined: no ovf port and no extra register; behaviour otherwise identical.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x33, cin=0, start pulse -> busy high 8 cycles, done one cycle after; sum=0x8D, cout=0; sum unchanged during busy.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1. Then op_a=0xFF, op_b=0x00, cin=1 -> sum=0x00, cout=1. Then op_a=0x00, op_b=0x00, cin=0 -> sum=0x00, cout=0.
- Start 0x10+0x20. Pulse start with 0xFF+0xFF at cycle 3 of RUN -> ignored; result sum=0x30, cout=0 at the expected done cycle.
- Start 0xAA+0x55, assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse. A subsequent 0x01+0x01 gives sum=0x02 after 8+1 cycles.
- Back-to-back: start held during the DONE cycle with 0x0F+0x01 after a 0x80+0x7F run -> first result 0xFF/cout=0 with done for one cycle; second run begins immediately; second result 0x10/cout=0 exactly 9 cycles later.
- With SERIAL_ADD_OVF_EN:
  - 0x7F+0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
  - 0x80+0x80 -> sum=0x00, cout=1, ovf=1.
  - 0xFF+0x01 -> sum=0x00, cout=1, ovf=0.

Source files
------------

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder controller: one full-adder slice per cycle, carry held between slices.
// Optional SERIAL_ADD_OVF_EN adds a registered two's-complement overflow flag (ovf).
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic w_s;
    logic w_c;
    logic w_last;
    logic w_accept;

    // Single full-adder cell operating on the current LSB slice
    assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_accept = start;
                w_next   = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            // Flags follow the next state so they line up with the state register
            busy <= (w_next == S_RUN);
            done <= (w_next == S_DONE);
            if (w_accept) begin
                r_a     <= op_a;
                r_b     <= op_b;
                r_carry <= cin;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_res   <= {w_s, r_res[WIDTH-1:1]};
                r_carry <= w_c;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    sum  <= {w_s, r_res[WIDTH-1:1]};
                    cout <= w_c;
`ifdef SERIAL_ADD_OVF_EN
                    // r_carry here is the carry into the MSB slice
                    ovf  <= r_carry ^ w_c;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq (WIDTH=8); ovf checks compiled in with SERIAL_ADD_OVF_EN.
module tb_serial_add_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int t_acc = 0;
    logic [W+1:0] exp_q[$];   // {ovf, cout, sum}

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                            input bit sync);
        logic [W:0] full;
        logic       v;
        if (sync) @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; cin = ci;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        v = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        exp_q.push_back({v, full});
        @(negedge clk);
        start = 1'b0;
        t_acc = cyc;
    endtask

    task automatic collect_result(input string name);
        logic [W+1:0] e;
        logic [W-1:0] s0;
        bit           got;
        got = 0;
        s0 = sum;
        for (int i = 0; i < W + 6; i++) begin
            if (done) begin got = 1; break; end
            tests++;
            if (busy !== 1'b1 || sum !== s0) begin
                fails++;
                $display("FAIL %s_run busy=%b sum=%h required busy=1 sum=%h", name, busy, sum, s0);
            end
            @(negedge clk);
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s_timeout done never seen", name);
            return;
        end
        e = exp_q.pop_front();
        if (cyc - t_acc !== W || busy !== 1'b0 || {cout, sum} !== e[W:0]) begin
            fails++;
            $display("FAIL %s lat=%0d busy=%b cout/sum=%h required lat=%0d busy=0 cout/sum=%h",
                     name, cyc - t_acc, busy, {cout, sum}, W, e[W:0]);
        end
`ifdef SERIAL_ADD_OVF_EN
        tests++;
        if (ovf !== e[W+1]) begin
            fails++;
            $display("FAIL %s_ovf got=%b required=%b", name, ovf, e[W+1]);
        end
`endif
    endtask

    task automatic test_done_drop(input string name);
        logic [W:0] held;
        held = {cout, sum};
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== held) begin
            fails++;
            $display("FAIL %s_drop done=%b busy=%b cout/sum=%h required 0 0 %h",
                     name, done, busy, {cout, sum}, held);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, cout, sum} !== '0) begin
            fails++;
            $display("FAIL reset busy=%b done=%b cout=%b sum=%h required all 0", busy, done, cout, sum);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        start_op(8'h5A, 8'h33, 1'b0, 1);
        collect_result("basic");
        test_done_drop("basic");
    endtask

    task automatic test_carry();
        start_op(8'hFF, 8'h01, 1'b0, 1); collect_result("wrap");  test_done_drop("wrap");
        start_op(8'hFF, 8'h00, 1'b1, 1); collect_result("cin");   test_done_drop("cin");
        start_op(8'h00, 8'h00, 1'b0, 1); collect_result("zero");  test_done_drop("zero");
        start_op(8'hFF, 8'hFF, 1'b1, 1); collect_result("max");   test_done_drop("max");
    endtask

    task automatic test_ignore_start();
        start_op(8'h10, 8'h20, 1'b0, 1);
        @(negedge clk);
        start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect_result("ignore");
        test_done_drop("ignore");
    endtask

    task automatic test_reset_mid();
        start_op(8'hAA, 8'h55, 1'b0, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        tests++;
        if ({busy, done, cout, sum} !== '0) begin
            fails++;
            $display("FAIL mid_reset busy=%b done=%b cout=%b sum=%h required all 0", busy, done, cout, sum);
        end
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_nodone done=%b busy=%b required 0 0", done, busy);
            end
        end
        start_op(8'h01, 8'h01, 1'b0, 1);
        collect_result("after_rst");
        test_done_drop("after_rst");
    endtask

    task automatic test_back_to_back();
        start_op(8'h80, 8'h7F, 1'b0, 1);
        collect_result("b2b_first");
        start_op(8'h0F, 8'h01, 1'b0, 0);
        tests++;
        if (done !== 1'b0 || busy !== 1'b1 || sum !== 8'hFF) begin
            fails++;
            $display("FAIL b2b_restart done=%b busy=%b sum=%h required 0 1 ff", done, busy, sum);
        end
        collect_result("b2b_second");
        test_done_drop("b2b_second");
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        start_op(8'h7F, 8'h01, 1'b0, 1); collect_result("ovf_pos"); test_done_drop("ovf_pos");
        start_op(8'h80, 8'h80, 1'b0, 1); collect_result("ovf_neg"); test_done_drop("ovf_neg");
        start_op(8'hFF, 8'h01, 1'b0, 1); collect_result("ovf_no");  test_done_drop("ovf_no");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover count=%0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
